// File: rtl/ram_dma_ctrl.sv
// Block-copy / fill engine that drives the write and read ports of a dual-port RAM.
// Optional feature: define RAM_DMA_CHKSUM_EN to add an XOR checksum of all words written by a command.
module ram_dma_ctrl #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [ADDR_W-1:0] ram_rd_addr,
    output logic [DATA_W-1:0] ram_wr_data,
`ifdef RAM_DMA_CHKSUM_EN
    output logic [DATA_W-1:0] chksum,
`endif
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_DRAIN,
        S_FILL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] next_wr_addr;

    // The first copy write goes to the latched destination; later ones step from the last write.
    assign next_wr_addr = wr_q ? wr_addr_q + ADDR_W'(1) : dst_q;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_d     = dst_q;
        fill_d    = fill_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        rd_addr_d = '0;
        wr_addr_d = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dst_d  = dst_addr;
                    fill_d = fill_val;
                    cnt_d  = len - CW'(1);
                    if (len == '0) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else if (!mode) begin
                        state_d   = S_COPY;
                        rd_d      = 1'b1;
                        rd_addr_d = src_addr;
                    end else begin
                        state_d   = S_FILL;
                        wr_d      = 1'b1;
                        wr_addr_d = dst_addr;
                    end
                end
            end
            S_COPY: begin
                wr_d      = 1'b1;
                wr_addr_d = next_wr_addr;
                if (cnt_q != '0) begin
                    rd_d      = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_FILL: begin
                if (cnt_q != '0) begin
                    wr_d      = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: asynchronous reset in the sensitivity list, and <= for all state so every register samples together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dst_q     <= '0;
            fill_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dst_q     <= dst_d;
            fill_q    <= fill_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign busy        = (state_q == S_COPY) || (state_q == S_DRAIN) || (state_q == S_FILL);
    assign done        = (state_q == S_DONE);
    assign ram_rd      = rd_q;
    assign ram_wr      = wr_q;
    assign ram_en      = rd_q | wr_q;
    assign ram_rd_addr = rd_addr_q;
    assign ram_wr_addr = wr_addr_q;
    // Copy data passes straight from the RAM read port, which already carries the one-cycle read latency.
    assign ram_wr_data = !wr_q             ? '0 :
                         (state_q == S_FILL) ? fill_q : ram_rd_data;

`ifdef RAM_DMA_CHKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == S_IDLE && start) begin
            chk_d = '0;
        end else if (wr_q) begin
            chk_d = chk_q ^ ram_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chksum = chk_q;
`endif

endmodule

// File: tb/tb_ram_dma_ctrl.sv
// Self-checking bench for ram_dma_ctrl: table of directed commands plus hand-written corner sequences.
// Checksum checks are compiled in when RAM_DMA_CHKSUM_EN is defined.
module tb_ram_dma_ctrl;

    localparam int AW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_val = '0;
    logic          busy, done, ram_en, ram_wr, ram_rd;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data = '0;
`ifdef RAM_DMA_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    ram_dma_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
`ifdef RAM_DMA_CHKSUM_EN
        .chksum      (chksum),
`endif
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .fill_val    (fill_val),
        .busy        (busy),
        .done        (done),
        .ram_en      (ram_en),
        .ram_wr      (ram_wr),
        .ram_rd      (ram_rd),
        .ram_wr_addr (ram_wr_addr),
        .ram_rd_addr (ram_rd_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with a registered read; a same-cycle read sees pre-write contents.
    logic [DW-1:0] mem [64];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd) ram_rd_data <= mem[ram_rd_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk);
        #1;
        pre_we   = 1'b0;
    endtask

    int            busy_n, wr_n, rd_n, done_n, done_cyc, first_wr_cyc, first_rd_cyc, en_err;
    logic [AW-1:0] wa [128];
    logic [AW-1:0] ra [128];
    logic [DW-1:0] wd [128];

    // Issues one command and records activity until the done pulse (bounded); returns in IDLE.
    task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [AW:0] l, input logic [DW-1:0] f);
        mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = ~m; src_addr = ~s; dst_addr = ~d; len = ~l; fill_val = ~f;
        busy_n = 0; wr_n = 0; rd_n = 0; done_n = 0; en_err = 0;
        done_cyc = -1; first_wr_cyc = -1; first_rd_cyc = -1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (ram_en !== (ram_wr | ram_rd)) en_err++;
            if (ram_rd) begin
                if (rd_n == 0) first_rd_cyc = cyc;
                if (rd_n < 128) ra[rd_n] = ram_rd_addr;
                rd_n++;
            end
            if (ram_wr) begin
                if (wr_n == 0) first_wr_cyc = cyc;
                if (wr_n < 128) begin
                    wa[wr_n] = ram_wr_addr;
                    wd[wr_n] = ram_wr_data;
                end
                wr_n++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          mode;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW:0]   len;
        logic [DW-1:0] fv;
        int            exp_busy;
        int            exp_wr;
        int            exp_rd;
        int            exp_done;
        int            exp_first_wr_cyc;
        logic [AW-1:0] exp_first_wa;
        logic [AW-1:0] exp_last_wa;
        logic [DW-1:0] exp_first_wd;
        logic [DW-1:0] exp_last_wd;
        logic [DW-1:0] exp_chk;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vec_t v;
        int   e;
        int   dn;
        int   extra;

        // Reset state
        #3 rst = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'({busy, done, ram_en, ram_wr, ram_rd, ram_wr_addr, ram_rd_addr, ram_wr_data}), 32'h0);
`ifdef RAM_DMA_CHKSUM_EN
        check("reset_chksum", 32'(chksum), 32'h0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        preload(6'h10, 8'h11); preload(6'h11, 8'h22); preload(6'h12, 8'h33); preload(6'h13, 8'h44);
        preload(6'h3E, 8'h61); preload(6'h3F, 8'h62); preload(6'h00, 8'h63);

        //            mode src    dst    len fv     busy wr rd done fwc fwa    lwa    fwd    lwd    chk
        vecs[0] = '{1'b0, 6'h10, 6'h20, 7'd4,  8'h00, 5,  4, 4, 6,  2, 6'h20, 6'h23, 8'h11, 8'h44, 8'h44};
        vecs[1] = '{1'b0, 6'h20, 6'h21, 7'd3,  8'h00, 4,  3, 3, 5,  2, 6'h21, 6'h23, 8'h11, 8'h33, 8'h00};
        vecs[2] = '{1'b0, 6'h3E, 6'h08, 7'd3,  8'h00, 4,  3, 3, 5,  2, 6'h08, 6'h0A, 8'h61, 8'h63, 8'h60};
        vecs[3] = '{1'b1, 6'h00, 6'h15, 7'd0,  8'hFF, 0,  0, 0, 1,  0, 6'h00, 6'h00, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 6'h00, 6'h3E, 7'd4,  8'hA5, 4,  4, 0, 5,  1, 6'h3E, 6'h01, 8'hA5, 8'hA5, 8'h00};
        vecs[5] = '{1'b1, 6'h00, 6'h00, 7'd64, 8'h5A, 64, 64, 0, 65, 1, 6'h00, 6'h3F, 8'h5A, 8'h5A, 8'h00};

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            run_cmd(v.mode, v.src, v.dst, v.len, v.fv);
            check($sformatf("v%0d_done_cycle", i), 32'(done_cyc), 32'(v.exp_done));
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(v.exp_busy));
            check($sformatf("v%0d_wr_count", i), 32'(wr_n), 32'(v.exp_wr));
            check($sformatf("v%0d_rd_count", i), 32'(rd_n), 32'(v.exp_rd));
            check($sformatf("v%0d_ram_en", i), 32'(en_err), 32'h0);
            if (v.exp_wr > 0 && wr_n == v.exp_wr) begin
                check($sformatf("v%0d_first_wr_cycle", i), 32'(first_wr_cyc), 32'(v.exp_first_wr_cyc));
                check($sformatf("v%0d_first_wr_addr", i), 32'(wa[0]), 32'(v.exp_first_wa));
                check($sformatf("v%0d_last_wr_addr", i), 32'(wa[wr_n-1]), 32'(v.exp_last_wa));
                check($sformatf("v%0d_first_wr_data", i), 32'(wd[0]), 32'(v.exp_first_wd));
                check($sformatf("v%0d_last_wr_data", i), 32'(wd[wr_n-1]), 32'(v.exp_last_wd));
                e = 0;
                for (int k = 0; k < wr_n; k++) if (wa[k] !== AW'(int'(v.exp_first_wa) + k)) e++;
                check($sformatf("v%0d_wr_addr_seq", i), 32'(e), 32'h0);
            end
            if (v.exp_rd > 0 && rd_n == v.exp_rd) begin
                check($sformatf("v%0d_first_rd_cycle", i), 32'(first_rd_cyc), 32'd1);
                e = 0;
                for (int k = 0; k < rd_n; k++) if (ra[k] !== AW'(int'(v.src) + k)) e++;
                check($sformatf("v%0d_rd_addr_seq", i), 32'(e), 32'h0);
            end
`ifdef RAM_DMA_CHKSUM_EN
            check($sformatf("v%0d_chksum", i), 32'(chksum), 32'(v.exp_chk));
`endif
        end

        e = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== 8'h5A) e++;
        check("fill64_ram_contents", 32'(e), 32'h0);

        // start held high through a copy and its DONE cycle: must be ignored
        for (int k = 0; k < 8; k++) preload(AW'(6'h10 + k), DW'(8'h80 + k));
        mode = 1'b0; src_addr = 6'h10; dst_addr = 6'h30; len = 7'd8; fill_val = 8'h00; start = 1'b1;
        @(posedge clk);
        #1;
        mode = 1'b1; len = 7'd3; fill_val = 8'hEE;
        wr_n = 0; dn = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (ram_wr) wr_n++;
            if (done) begin
                dn++;
                break;
            end
        end
        @(posedge clk);
        #1 start = 1'b0;
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy || done || ram_en) extra++;
        end
        check("repulse_wr_count", 32'(wr_n), 32'd8);
        check("repulse_done_count", 32'(dn), 32'd1);
        check("repulse_no_restart", 32'(extra), 32'h0);
        e = 0;
        for (int k = 0; k < 8; k++) if (mem[6'h30 + k] !== DW'(8'h80 + k)) e++;
        check("repulse_ram_contents", 32'(e), 32'h0);

        // Asynchronous reset during beat 2 of a copy of length 8
        @(posedge clk);
        #1;
        mode = 1'b0; src_addr = 6'h10; dst_addr = 6'h38; len = 7'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("beat2_rd_addr", 32'({ram_rd, ram_rd_addr}), 32'({1'b1, 6'h12}));
        check("beat2_wr_addr", 32'({ram_wr, ram_wr_addr}), 32'({1'b1, 6'h39}));
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'({busy, done, ram_en, ram_wr, ram_rd, ram_wr_addr, ram_rd_addr, ram_wr_data}), 32'h0);
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("abort_no_done", 32'(dn), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_written_word", 32'(mem[6'h38]), 32'h80);
        check("abort_unwritten_word", 32'(mem[6'h39]), 32'h5A);
        run_cmd(1'b0, 6'h38, 6'h3A, 7'd2, 8'h00);
        check("after_abort_done_cycle", 32'(done_cyc), 32'd4);
        check("after_abort_wr_count", 32'(wr_n), 32'd2);
        check("after_abort_data", 32'({mem[6'h3A], mem[6'h3B]}), 32'h805A);

`ifdef RAM_DMA_CHKSUM_EN
        run_cmd(1'b1, 6'h00, 6'h00, 7'd3, 8'h0F);
        check("chksum_fill", 32'(chksum), 32'h0F);
        preload(6'h28, 8'h01); preload(6'h29, 8'h02); preload(6'h2A, 8'h04);
        run_cmd(1'b0, 6'h28, 6'h2C, 7'd3, 8'h00);
        check("chksum_copy", 32'(chksum), 32'h07);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
